// File: rtl/msi_snoop_cache.sv
// msi_snoop_cache: direct-mapped write-back data cache with MSI snooping.
// One processor request is handled at a time. A one-entry flush buffer carries
// write-backs forced by remote snoops and outranks the cache's own bus messages.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ready for a processor request
// LOOKUP    | latched request checked against the indexed line
// VWB       | broadcasting write-back of the modified victim line
// SEND      | broadcasting RDMISS (load) or INVAL (store) for the request
// WAIT_FILL | load miss broadcast done, waiting for fill data
// RESP      | one-cycle completion pulse
module msi_snoop_cache #(
   parameter logic [1:0] NAME   = 2'd0,
   parameter int         LINES  = 4,
   parameter int         ADDR_W = 3,
   parameter int         DATA_W = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic [ADDR_W-1:0]          req_addr,
   input  logic [DATA_W-1:0]          req_wdata,
   output logic                       resp_valid,
   output logic                       resp_hit,
   output logic [DATA_W-1:0]          resp_data,
   output logic                       bus_req,
   input  logic                       bus_grant,
   output logic [2+ADDR_W+DATA_W-1:0] bus_msg,
   input  logic                       snoop_valid,
   input  logic [1:0]                 snoop_src,
   input  logic [2+ADDR_W+DATA_W-1:0] snoop_msg,
   input  logic                       fill_valid,
   input  logic [DATA_W-1:0]          fill_data
);

   localparam int IDX_W = $clog2(LINES);
   localparam int MSG_W = 2 + ADDR_W + DATA_W;

   localparam logic [1:0] ST_I = 2'd0;
   localparam logic [1:0] ST_S = 2'd1;
   localparam logic [1:0] ST_M = 2'd2;

   localparam logic [1:0] MSG_RDMISS = 2'd1;
   localparam logic [1:0] MSG_INVAL  = 2'd2;
   localparam logic [1:0] MSG_WB     = 2'd3;

   typedef enum logic [2:0] {
      IDLE, LOOKUP, VWB, SEND, WAIT_FILL, RESP
   } fsm_t;

   fsm_t state, state_nxt;

   logic [1:0]        line_st   [LINES];
   logic [ADDR_W-1:0] line_tag  [LINES];
   logic [DATA_W-1:0] line_data [LINES];

   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [IDX_W-1:0]  r_idx;

   logic              flush_valid;
   logic [MSG_W-1:0]  flush_msg;

   logic [1:0]        snp_type;
   logic [ADDR_W-1:0] snp_addr;
   logic [IDX_W-1:0]  snp_idx;
   logic              snp_hit;
   logic              snp_flush;
   logic              unused_snoop_data;

   logic              lookup_hit;
   logic              victim_m;
   logic [MSG_W-1:0]  own_msg;
   logic [MSG_W-1:0]  vwb_msg;

   logic              own_upd;
   logic [1:0]        own_st;
   logic [DATA_W-1:0] own_data;
   logic              resp_load;
   logic              resp_hit_nxt;
   logic [DATA_W-1:0] resp_data_nxt;

   assign r_idx = r_addr[IDX_W-1:0];

   // snooped data field carries nothing the snooper needs
   assign snp_type          = snoop_msg[MSG_W-1 -: 2];
   assign snp_addr          = snoop_msg[DATA_W +: ADDR_W];
   assign snp_idx           = snp_addr[IDX_W-1:0];
   assign unused_snoop_data = ^snoop_msg[DATA_W-1:0];

   assign snp_hit   = snoop_valid && (snoop_src != NAME) &&
                      (line_tag[snp_idx] == snp_addr) && (line_st[snp_idx] != ST_I);
   assign snp_flush = snp_hit && (line_st[snp_idx] == ST_M) &&
                      ((snp_type == MSG_RDMISS) || (snp_type == MSG_INVAL));

   assign lookup_hit = (line_tag[r_idx] == r_addr) && (line_st[r_idx] != ST_I);
   assign victim_m   = !lookup_hit && (line_st[r_idx] == ST_M);

   assign own_msg = {(r_write ? MSG_INVAL : MSG_RDMISS), r_addr, {DATA_W{1'b0}}};
   assign vwb_msg = {MSG_WB, line_tag[r_idx], line_data[r_idx]};

   // state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next state, handshake outputs and line-update controls
   always_comb begin
      state_nxt     = state;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      bus_req       = flush_valid;
      bus_msg       = flush_valid ? flush_msg : '0;
      own_upd       = 1'b0;
      own_st        = ST_I;
      own_data      = '0;
      resp_load     = 1'b0;
      resp_hit_nxt  = 1'b0;
      resp_data_nxt = '0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = LOOKUP;
         end
         LOOKUP: begin
            if (lookup_hit && !r_write) begin
               state_nxt     = RESP;
               resp_load     = 1'b1;
               resp_hit_nxt  = 1'b1;
               resp_data_nxt = line_data[r_idx];
            end else if (lookup_hit && (line_st[r_idx] == ST_M)) begin
               own_upd       = 1'b1;
               own_st        = ST_M;
               own_data      = r_wdata;
               state_nxt     = RESP;
               resp_load     = 1'b1;
               resp_hit_nxt  = 1'b1;
               resp_data_nxt = r_wdata;
            end else if (victim_m) begin
               state_nxt = VWB;
            end else begin
               state_nxt = SEND;
            end
         end
         VWB: begin
            bus_req = 1'b1;
            if (!flush_valid) begin
               bus_msg = vwb_msg;
               if (bus_grant) state_nxt = SEND;
            end
         end
         SEND: begin
            bus_req = 1'b1;
            if (!flush_valid) begin
               bus_msg = own_msg;
               if (bus_grant) begin
                  if (r_write) begin
                     own_upd       = 1'b1;
                     own_st        = ST_M;
                     own_data      = r_wdata;
                     state_nxt     = RESP;
                     resp_load     = 1'b1;
                     resp_data_nxt = r_wdata;
                  end else begin
                     state_nxt = WAIT_FILL;
                  end
               end
            end
         end
         WAIT_FILL: begin
            if (fill_valid) begin
               own_upd       = 1'b1;
               own_st        = ST_S;
               own_data      = fill_data;
               state_nxt     = RESP;
               resp_load     = 1'b1;
               resp_data_nxt = fill_data;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // request capture on acceptance
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (state == IDLE && req_valid) begin
         r_write <= req_write;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
      end
   end

   // response registers, loaded on entry to RESP
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         resp_hit  <= 1'b0;
         resp_data <= '0;
      end else if (resp_load) begin
         resp_hit  <= resp_hit_nxt;
         resp_data <= resp_data_nxt;
      end
   end

   // line array and flush buffer: snoop effects first, own completion last so it wins
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LINES; i++) begin
            line_st[i]   <= ST_I;
            line_tag[i]  <= '0;
            line_data[i] <= '0;
         end
         flush_valid <= 1'b0;
         flush_msg   <= '0;
      end else begin
         if (flush_valid && bus_grant)
            flush_valid <= 1'b0;
         if (snp_hit) begin
            if (snp_type == MSG_RDMISS)
               line_st[snp_idx] <= ST_S;
            else if (snp_type == MSG_INVAL)
               line_st[snp_idx] <= ST_I;
            if (snp_flush) begin
               flush_valid <= 1'b1;
               flush_msg   <= {MSG_WB, line_tag[snp_idx], line_data[snp_idx]};
            end
         end
         if (own_upd) begin
            line_st[r_idx]   <= own_st;
            line_tag[r_idx]  <= r_addr;
            line_data[r_idx] <= own_data;
         end
      end
   end

endmodule

// File: tb/tb_msi_snoop_cache.sv
// Testbench for msi_snoop_cache: directed scenarios then randomized traffic,
// checked against a line-level model of the MSI rules.
module tb_msi_snoop_cache;

   localparam logic [1:0] NAME = 2'd1;
   localparam logic [1:0] T_IDLE = 2'd0, T_RD = 2'd1, T_INV = 2'd2, T_WB = 2'd3;
   localparam logic [1:0] L_I = 2'd0, L_S = 2'd1, L_M = 2'd2;

   logic       clock = 1'b0;
   logic       reset;
   logic       req_valid, req_ready, req_write;
   logic [2:0] req_addr;
   logic [3:0] req_wdata;
   logic       resp_valid, resp_hit;
   logic [3:0] resp_data;
   logic       bus_req, bus_grant;
   logic [8:0] bus_msg;
   logic       snoop_valid;
   logic [1:0] snoop_src;
   logic [8:0] snoop_msg;
   logic       fill_valid;
   logic [3:0] fill_data;

   msi_snoop_cache #(.NAME(NAME), .LINES(4), .ADDR_W(3), .DATA_W(4)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data),
      .bus_req(bus_req), .bus_grant(bus_grant), .bus_msg(bus_msg),
      .snoop_valid(snoop_valid), .snoop_src(snoop_src), .snoop_msg(snoop_msg),
      .fill_valid(fill_valid), .fill_data(fill_data)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [1:0] m_st   [4];
   logic [2:0] m_tag  [4];
   logic [3:0] m_data [4];
   logic [8:0] m_flushq [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   function automatic logic [8:0] mk(input logic [1:0] t, input logic [2:0] a, input logic [3:0] d);
      return {t, a, d};
   endfunction

   task automatic model_clear;
      for (int k = 0; k < 4; k++) begin
         m_st[k]   = L_I;
         m_tag[k]  = 3'd0;
         m_data[k] = 4'd0;
      end
      m_flushq.delete();
   endtask

   task automatic check_lines;
      for (int k = 0; k < 4; k++) begin
         logic [1:0] j;
         j = 2'(k);
         chk("line_st",   32'(dut.line_st[j]),   32'(m_st[j]));
         chk("line_tag",  32'(dut.line_tag[j]),  32'(m_tag[j]));
         chk("line_data", 32'(dut.line_data[j]), 32'(m_data[j]));
      end
   endtask

   // one-cycle bus message from another cache, with the model applying the MSI snoop rules
   task automatic snoop(input logic [1:0] src, input logic [1:0] t, input logic [2:0] a);
      logic [1:0] i;
      i = a[1:0];
      snoop_valid = 1'b1;
      snoop_src   = src;
      snoop_msg   = mk(t, a, 4'($urandom));
      tick;
      snoop_valid = 1'b0;
      snoop_msg   = 9'd0;
      if (src != NAME && m_tag[i] == a && m_st[i] != L_I) begin
         if (t == T_RD) begin
            if (m_st[i] == L_M) m_flushq.push_back(mk(T_WB, a, m_data[i]));
            m_st[i] = L_S;
         end else if (t == T_INV) begin
            if (m_st[i] == L_M) m_flushq.push_back(mk(T_WB, a, m_data[i]));
            m_st[i] = L_I;
         end
      end
   endtask

   task automatic drain;
      while (m_flushq.size() > 0) begin
         chk("flush_req", 32'(bus_req), 32'd1);
         chk("flush_msg", 32'(bus_msg), 32'(m_flushq.pop_front()));
         bus_grant = 1'b1;
         tick;
         bus_grant = 1'b0;
      end
      chk("bus_quiet", 32'(bus_req), 32'd0);
   endtask

   // complete processor access; grant held off gdly cycles per message, fill after fdly cycles
   task automatic access(input logic wr, input logic [2:0] a, input logic [3:0] d,
                         input logic [3:0] fill, input int gdly, input int fdly);
      logic [1:0] i;
      logic       hit, own_hit;
      logic [3:0] exp_data;
      logic [8:0] exp_q [$];
      int         n;
      i = a[1:0];
      hit = (m_tag[i] == a) && (m_st[i] != L_I);
      own_hit = hit && (!wr || m_st[i] == L_M);
      if (wr) exp_data = d;
      else if (hit) exp_data = m_data[i];
      else exp_data = fill;
      if (!own_hit) begin
         exp_q = m_flushq;
         m_flushq.delete();
         if (!hit && m_st[i] == L_M) exp_q.push_back(mk(T_WB, m_tag[i], m_data[i]));
         exp_q.push_back(mk(wr ? T_INV : T_RD, a, 4'h0));
      end
      chk("req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      tick;
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = 3'($urandom);
      req_wdata = 4'($urandom);
      if (own_hit) begin
         chk("hit_latency", 32'(resp_valid), 32'd0);
         tick;
      end else begin
         while (exp_q.size() > 0) begin
            n = 0;
            while (!bus_req && n < 20) begin
               tick;
               n++;
            end
            chk("bus_req", 32'(bus_req), 32'd1);
            for (int k = 0; k < gdly; k++) begin
               chk("held_msg", 32'(bus_msg), 32'(exp_q[0]));
               fill_valid = 1'($urandom);
               fill_data  = 4'($urandom);
               tick;
               chk("held_req", 32'(bus_req), 32'd1);
            end
            fill_valid = 1'b0;
            chk("bus_msg", 32'(bus_msg), 32'(exp_q.pop_front()));
            bus_grant = 1'b1;
            tick;
            bus_grant = 1'b0;
         end
         if (!wr) begin
            for (int k = 0; k < fdly; k++) begin
               chk("early_resp", 32'(resp_valid), 32'd0);
               tick;
            end
            fill_valid = 1'b1;
            fill_data  = fill;
            tick;
            fill_valid = 1'b0;
            fill_data  = 4'($urandom);
         end
      end
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("resp_hit",   32'(resp_hit),   32'(own_hit));
      chk("resp_data",  32'(resp_data),  32'(exp_data));
      if (wr) begin
         m_st[i] = L_M; m_tag[i] = a; m_data[i] = d;
      end else if (!hit) begin
         m_st[i] = L_S; m_tag[i] = a; m_data[i] = fill;
      end
      tick;
      chk("resp_pulse", 32'(resp_valid), 32'd0);
   endtask

   int wait_n;

   initial begin
      req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
      bus_grant = 0; snoop_valid = 0; snoop_src = 0; snoop_msg = 0;
      fill_valid = 0; fill_data = 0;
      reset = 1'b1;
      model_clear;
      tick;
      chk("rst_ready",     32'(req_ready),  32'd1);
      chk("rst_resp",      32'(resp_valid), 32'd0);
      chk("rst_resp_hit",  32'(resp_hit),   32'd0);
      chk("rst_resp_data", 32'(resp_data),  32'd0);
      chk("rst_bus_req",   32'(bus_req),    32'd0);
      chk("rst_bus_msg",   32'(bus_msg),    32'd0);
      reset = 1'b0;
      tick;
      check_lines;

      // load miss, then reload hit
      access(1'b0, 3'b101, 4'h0, 4'hA, 0, 0);
      access(1'b0, 3'b101, 4'h0, 4'h0, 0, 0);
      // store over S line, then load hit
      access(1'b1, 3'b101, 4'h7, 4'h0, 1, 0);
      access(1'b0, 3'b101, 4'h0, 4'h0, 0, 0);
      // miss displacing modified victim
      access(1'b0, 3'b001, 4'h0, 4'h3, 2, 1);
      check_lines;

      // remote read of a modified line forces a flush ahead of own traffic
      access(1'b1, 3'b010, 4'h5, 4'h0, 0, 0);
      snoop(2'd0, T_RD, 3'b010);
      access(1'b0, 3'b011, 4'h0, 4'hC, 3, 0);
      check_lines;
      snoop(2'd0, T_INV, 3'b010);
      drain;
      check_lines;

      // own-id messages are ignored; a foreign invalidate flushes
      access(1'b1, 3'b010, 4'h9, 4'h0, 0, 0);
      snoop(NAME, T_INV, 3'b010);
      drain;
      check_lines;
      snoop(2'd2, T_INV, 3'b010);
      drain;
      check_lines;

      // grant withheld for five cycles
      access(1'b1, 3'b110, 4'h4, 4'h0, 5, 0);
      check_lines;

      // reset while waiting for fill
      req_valid = 1'b1; req_write = 1'b0; req_addr = 3'b111;
      tick;
      req_valid = 1'b0;
      wait_n = 0;
      while (!bus_req && wait_n < 20) begin
         tick;
         wait_n++;
      end
      chk("rf_bus_msg", 32'(bus_msg), 32'(mk(T_RD, 3'b111, 4'h0)));
      bus_grant = 1'b1;
      tick;
      bus_grant = 1'b0;
      chk("rf_wait", 32'(resp_valid), 32'd0);
      tick;
      reset = 1'b1;
      #1;
      model_clear;
      check_lines;
      fill_valid = 1'b1; fill_data = 4'hF;
      tick;
      fill_valid = 1'b0;
      reset = 1'b0;
      repeat (3) begin
         chk("rf_no_resp", 32'(resp_valid), 32'd0);
         tick;
      end
      chk("rf_ready", 32'(req_ready), 32'd1);
      chk("rf_bus",   32'(bus_req),   32'd0);
      check_lines;

      // randomized traffic mixed with foreign snoops
      repeat (120) begin
         if ($urandom_range(0, 3) == 0) begin
            snoop(2'($urandom), 2'($urandom), 3'($urandom));
            drain;
         end else begin
            access(1'($urandom), 3'($urandom), 4'($urandom), 4'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         end
         check_lines;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/msi_snoop_cache.md
Name: msi_snoop_cache

Overview:
- Clocked, parametrised successor to the step-driven MSI snooping cache. It is a direct-mapped, write-back data cache for one processor on the shared snooping bus.
- Processor side: valid/ready request port. Bus side: one-message-at-a-time granted broadcast port plus snoop input.
- Adds over the previous generation: configurable lines/address/data widths, arbitration handshake, victim write-back before miss, flush-on-snoop priority, memory fill handshake.

Parameters:
- NAME, 2'd0, processor id; bus messages whose snoop_src equals NAME are ignored by the snooper.
- LINES, 4, number of cache lines; power of 2, >=2; IDX_W = clog2(LINES).
- ADDR_W, 3, address width; full address stored as tag; index = addr[IDX_W-1:0]; ADDR_W >= IDX_W.
- DATA_W, 4, data width per line.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  processor request present.
- req_ready  out  1  cache can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_hit  out  1  request hit without a bus miss message.
- resp_data  out  DATA_W  load data (store: written data).
- bus_req  out  1  requests the bus for bus_msg.
- bus_grant  in  1  arbiter grant; message is broadcast in a cycle with bus_req && bus_grant.
- bus_msg  out  2+ADDR_W+DATA_W  {type, addr, data}.
- snoop_valid  in  1  a message is on the bus this cycle.
- snoop_src  in  2  sender id.
- snoop_msg  in  2+ADDR_W+DATA_W  {type, addr, data} broadcast.
- fill_valid  in  1  memory/peer fill data for the outstanding read miss.
- fill_data  in  DATA_W  fill value.

Behaviour:
- Line states: I=0, S=1, M=2. Bus types: IDLE=0, RDMISS=1, INVAL=2, WB=3; IDLE messages are ignored.
- Reset (async): all lines I, tags/data 0; FSM in IDLE; req_ready=1; resp_valid=0; resp_hit=0; resp_data=0; bus_req=0; bus_msg=0.
- Reset mid-operation aborts any request; no response is issued.
- FSM transitions:
  - IDLE -> LOOKUP when req_valid&&req_ready; request is latched.
  - LOOKUP, read hit (tag match, state != I) -> RESP.
  - LOOKUP, write hit in M -> update data, RESP.
  - LOOKUP, write hit in S -> SEND with INVAL.
  - LOOKUP, miss with victim in M -> VWB, sending {WB, victim tag, victim data}; then SEND.
  - LOOKUP, miss otherwise -> SEND (RDMISS for load, INVAL for store).
  - SEND -> load: WAIT_FILL; store: line={M, addr, wdata}, RESP.
  - WAIT_FILL on fill_valid -> line={S, addr, fill_data}, RESP; fill_valid ignored outside WAIT_FILL.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- bus_req is held with a stable bus_msg until granted; each message is issued on the grant edge. Read-hit latency: request edge -> resp_valid 2 cycles later.
- Snooping runs every cycle in every state when snoop_valid && snoop_src!=NAME and the indexed line's tag matches snoop addr with state != I:
  - RDMISS: if M, queue flush {WB, tag, data}; line -> S.
  - INVAL: if M, queue flush; line -> I.
  - WB: no state change.
- Flush queue is 1 entry and has priority over own VWB/SEND messages. Own message is deferred while the flush is pending.
- A snoop hitting while the flush entry is occupied cannot occur: the line is already non-M. A second RDMISS to an S line queues nothing.
- Simultaneous snoop and own update on the same line in one cycle: snoop update applies first, own update overwrites. The own transaction's bus message was already granted, so it is ordered later.
- Snoop invalidating the request line during SEND/WAIT_FILL does not cancel the request; completion writes per the FSM rules above.
- resp_hit=1 only for the LOOKUP->RESP path.

Test Plan:
- Defaults, NAME=1. Reset -> all four lines I, req_ready=1. Load addr 3'b101 -> bus_msg {RDMISS,101,0} on grant; fill 4'hA -> resp_data=A, resp_hit=0; reload -> resp_hit=1, resp_valid 2 cycles after request.
- Store 101,4'h7 over the S line -> {INVAL,101,0} sent; line M. Load 101 -> hit, data 7.
- Line 01 holds M {101,7}; load 001 -> {WB,101,7} issued first, then {RDMISS,001,0}; fill 3 -> line {S,001,3}.
- Line M {010,5}; snoop src=0 {RDMISS,010} -> flush {WB,010,5} before any own message; line S. Snoop {INVAL,010} -> line I.
- Snoop with src=1 {INVAL,010} on an M line -> ignored; line stays M, no flush.
- Hold bus_grant=0 for 5 cycles during SEND -> bus_req and bus_msg stable. Assert reset in WAIT_FILL -> no resp_valid; all lines I.
